// File: rtl/axi_llc_way_resolve_if.sv
// Bus bundle for the way-resolve stage: lookup input, eviction-box exchange
// and resolved-descriptor output. The slave modport is the resolve block's view.
interface axi_llc_way_resolve_if #(
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned IndexWidth       = 10,
  parameter int unsigned TagWidth         = 20
);
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [IndexWidth-1:0]       in_index_i;
  logic [TagWidth-1:0]         in_tag_i;
  logic [SetAssociativity-1:0] in_hit_i;
  logic [SetAssociativity-1:0] in_valid_ways_i;
  logic [SetAssociativity-1:0] in_dirty_ways_i;
  logic [SetAssociativity-1:0] in_spm_lock_i;

  logic                        evict_req_o;
  logic [SetAssociativity-1:0] evict_valid_ways_o;
  logic [SetAssociativity-1:0] evict_dirty_ways_o;
  logic [SetAssociativity-1:0] evict_spm_lock_o;
  logic [SetAssociativity-1:0] evict_way_ind_i;
  logic                        evict_flag_i;
  logic                        evict_valid_i;

  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [IndexWidth-1:0]       out_index_o;
  logic [TagWidth-1:0]         out_tag_o;
  logic [SetAssociativity-1:0] out_way_ind_o;
  logic                        out_hit_o;
  logic                        out_evict_o;
  logic                        out_no_way_o;

  modport slave (
    input  in_valid_i, in_index_i, in_tag_i, in_hit_i,
           in_valid_ways_i, in_dirty_ways_i, in_spm_lock_i,
           evict_way_ind_i, evict_flag_i, evict_valid_i, out_ready_i,
    output in_ready_o, evict_req_o, evict_valid_ways_o, evict_dirty_ways_o,
           evict_spm_lock_o, out_valid_o, out_index_o, out_tag_o,
           out_way_ind_o, out_hit_o, out_evict_o, out_no_way_o
  );

  modport master (
    output in_valid_i, in_index_i, in_tag_i, in_hit_i,
           in_valid_ways_i, in_dirty_ways_i, in_spm_lock_i,
           evict_way_ind_i, evict_flag_i, evict_valid_i, out_ready_i,
    input  in_ready_o, evict_req_o, evict_valid_ways_o, evict_dirty_ways_o,
           evict_spm_lock_o, out_valid_o, out_index_o, out_tag_o,
           out_way_ind_o, out_hit_o, out_evict_o, out_no_way_o
  );
endinterface

// File: rtl/axi_llc_way_resolve.sv
// Resolves the target way of one lookup: forwards a hit way, or asks the
// eviction box for a victim on a miss, then emits one resolved descriptor.
module axi_llc_way_resolve #(
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned IndexWidth       = 10,
  parameter int unsigned TagWidth         = 20,
  parameter int unsigned CntWidth         = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ctrl_clr_i,
  axi_llc_way_resolve_if.slave  bus,
  output logic [CntWidth-1:0]   hit_cnt_o,
  output logic [CntWidth-1:0]   miss_cnt_o,
  output logic [CntWidth-1:0]   evict_cnt_o
);

  typedef enum logic [1:0] {IDLE, EVICT, OUT} state_e;

  state_e state_reg, state_next;

  logic [IndexWidth-1:0]       index_reg;
  logic [TagWidth-1:0]         tag_reg;
  logic [SetAssociativity-1:0] valid_ways_reg;
  logic [SetAssociativity-1:0] dirty_ways_reg;
  logic [SetAssociativity-1:0] spm_lock_reg;
  logic [SetAssociativity-1:0] way_reg;
  logic                        hit_reg;
  logic                        evict_reg;
  logic                        no_way_reg;

  logic in_hs, out_hs, evict_hs, in_is_hit, in_all_spm;

  assign in_hs      = (state_reg == IDLE) && bus.in_valid_i;
  assign evict_hs   = (state_reg == EVICT) && bus.evict_valid_i;
  assign out_hs     = (state_reg == OUT) && bus.out_ready_i;
  assign in_is_hit  = |bus.in_hit_i;
  assign in_all_spm = &bus.in_spm_lock_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid_i) begin
          if (in_is_hit || in_all_spm) begin
            state_next = OUT;
          end else begin
            state_next = EVICT;
          end
        end
      end
      EVICT: begin
        if (bus.evict_valid_i) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.evict_req_o = 1'b0;
    bus.out_valid_o = 1'b0;
    case (state_reg)
      IDLE:    bus.in_ready_o  = 1'b1;
      EVICT:   bus.evict_req_o = 1'b1;
      OUT:     bus.out_valid_o = 1'b1;
      default: bus.in_ready_o  = 1'b0;
    endcase
  end

  // On a miss the hit vector is zero, so latching it directly also clears the way.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      index_reg      <= '0;
      tag_reg        <= '0;
      valid_ways_reg <= '0;
      dirty_ways_reg <= '0;
      spm_lock_reg   <= '0;
      way_reg        <= '0;
      hit_reg        <= 1'b0;
      evict_reg      <= 1'b0;
      no_way_reg     <= 1'b0;
    end else if (in_hs) begin
      index_reg      <= bus.in_index_i;
      tag_reg        <= bus.in_tag_i;
      valid_ways_reg <= bus.in_valid_ways_i;
      dirty_ways_reg <= bus.in_dirty_ways_i;
      spm_lock_reg   <= bus.in_spm_lock_i;
      way_reg        <= bus.in_hit_i;
      hit_reg        <= in_is_hit;
      evict_reg      <= 1'b0;
      no_way_reg     <= !in_is_hit && in_all_spm;
    end else if (evict_hs) begin
      way_reg        <= bus.evict_way_ind_i;
      evict_reg      <= bus.evict_flag_i;
    end
  end

  assign bus.evict_valid_ways_o = valid_ways_reg;
  assign bus.evict_dirty_ways_o = dirty_ways_reg;
  assign bus.evict_spm_lock_o   = spm_lock_reg;
  assign bus.out_index_o        = index_reg;
  assign bus.out_tag_o          = tag_reg;
  assign bus.out_way_ind_o      = way_reg;
  assign bus.out_hit_o          = hit_reg;
  assign bus.out_evict_o        = evict_reg;
  assign bus.out_no_way_o       = no_way_reg;

  // Counter order: 0 = hit, 1 = allocating miss, 2 = dirty eviction.
  logic [2:0]          cnt_inc;
  logic [CntWidth-1:0] cnt_reg [3];

  assign cnt_inc[0] = out_hs && hit_reg;
  assign cnt_inc[1] = out_hs && !hit_reg && !no_way_reg;
  assign cnt_inc[2] = out_hs && evict_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    always_ff @(posedge clk_i) begin
      if (rst_i || ctrl_clr_i) begin
        cnt_reg[gi] <= '0;
      end else if (cnt_inc[gi] && (cnt_reg[gi] != {CntWidth{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign hit_cnt_o   = cnt_reg[0];
  assign miss_cnt_o  = cnt_reg[1];
  assign evict_cnt_o = cnt_reg[2];

  a_hit_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    in_hs |-> $onehot0(bus.in_hit_i));
  a_hit_in_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    in_hs |-> ((bus.in_hit_i & ~bus.in_valid_ways_i) == '0));
  a_victim_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    evict_hs |-> $onehot(bus.evict_way_ind_i));
  a_victim_not_spm: assert property (@(posedge clk_i) disable iff (rst_i)
    evict_hs |-> ((bus.evict_way_ind_i & spm_lock_reg) == '0));
  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.out_valid_o && !bus.out_ready_i) |=>
      ($stable(bus.out_index_o) && $stable(bus.out_tag_o) &&
       $stable(bus.out_way_ind_o) && $stable(bus.out_hit_o) &&
       $stable(bus.out_evict_o) && $stable(bus.out_no_way_o)));

endmodule

// File: tb/tb_axi_llc_way_resolve.sv
// Randomized bench for the way-resolve stage: drives lookups and an eviction
// box, and compares every outcome against a descriptor-level reference model.
module tb_axi_llc_way_resolve;
  localparam int SA = 8;
  localparam int IW = 10;
  localparam int TW = 20;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [CW-1:0] hit_cnt, miss_cnt, evict_cnt;

  always #5 clk = ~clk;

  axi_llc_way_resolve_if #(.SetAssociativity(SA), .IndexWidth(IW), .TagWidth(TW)) bus ();

  axi_llc_way_resolve #(
    .SetAssociativity(SA), .IndexWidth(IW), .TagWidth(TW), .CntWidth(CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ctrl_clr_i (clr),
    .bus        (bus),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
    .evict_cnt_o(evict_cnt)
  );

  int checks = 0;
  int errors = 0;
  int m_hit = 0, m_miss = 0, m_evict = 0;
  int txn_no = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Random onehot picked from the set bits of m (zero when m is empty).
  function automatic logic [SA-1:0] pick(input logic [SA-1:0] m);
    logic [SA-1:0] r;
    int k;
    r = '0;
    if (m == '0) return r;
    k = $urandom_range($countones(m) - 1, 0);
    for (int i = 0; i < SA; i++) begin
      if (m[i]) begin
        if (k == 0) begin
          r[i] = 1'b1;
          return r;
        end
        k--;
      end
    end
    return r;
  endfunction

  task automatic check_cnt();
    check("hit_cnt", hit_cnt, m_hit);
    check("miss_cnt", miss_cnt, m_miss);
    check("evict_cnt", evict_cnt, m_evict);
  endtask

  task automatic check_out(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           input logic [SA-1:0] way, input logic hit,
                           input logic ev, input logic nw);
    check("out_valid", bus.out_valid_o, 1'b1);
    check("in_ready_busy", bus.in_ready_o, 1'b0);
    check("out_index", bus.out_index_o, idx);
    check("out_tag", bus.out_tag_o, tag);
    check("out_way", bus.out_way_ind_o, way);
    check("out_hit", bus.out_hit_o, hit);
    check("out_evict", bus.out_evict_o, ev);
    check("out_no_way", bus.out_no_way_o, nw);
  endtask

  task automatic scramble_inputs();
    bus.in_index_i      = IW'($urandom);
    bus.in_tag_i        = TW'($urandom);
    bus.in_hit_i        = SA'($urandom);
    bus.in_valid_ways_i = SA'($urandom);
    bus.in_dirty_ways_i = SA'($urandom);
    bus.in_spm_lock_i   = SA'($urandom);
  endtask

  task automatic start_txn(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           input logic [SA-1:0] hit, input logic [SA-1:0] vld,
                           input logic [SA-1:0] drt, input logic [SA-1:0] spm);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready_o, 1'b1);
    bus.in_valid_i      = 1'b1;
    bus.in_index_i      = idx;
    bus.in_tag_i        = tag;
    bus.in_hit_i        = hit;
    bus.in_valid_ways_i = vld;
    bus.in_dirty_ways_i = drt;
    bus.in_spm_lock_i   = spm;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    scramble_inputs();
  endtask

  task automatic run_txn(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                         input logic [SA-1:0] hit, input logic [SA-1:0] vld,
                         input logic [SA-1:0] drt, input logic [SA-1:0] spm,
                         input logic [SA-1:0] box_way_in, input int delay,
                         input int stall, input logic clr_hs);
    logic is_hit, no_way, exp_ev, box_flag;
    logic [SA-1:0] exp_way, box_way;
    is_hit  = (hit != '0);
    no_way  = !is_hit && (spm == '1);
    exp_way = hit;
    exp_ev  = 1'b0;
    start_txn(idx, tag, hit, vld, drt, spm);
    if (!is_hit && !no_way) begin
      box_way  = (box_way_in != '0) ? box_way_in : pick(~spm);
      box_flag = |(box_way & drt);
      check("evict_req", bus.evict_req_o, 1'b1);
      check("out_valid_evict", bus.out_valid_o, 1'b0);
      check("evict_valid_ways", bus.evict_valid_ways_o, vld);
      check("evict_dirty_ways", bus.evict_dirty_ways_o, drt);
      check("evict_spm_lock", bus.evict_spm_lock_o, spm);
      for (int c = 0; c < delay; c++) begin
        @(negedge clk);
        check("evict_req_hold", bus.evict_req_o, 1'b1);
        check("evict_dirty_hold", bus.evict_dirty_ways_o, drt);
      end
      bus.evict_valid_i   = 1'b1;
      bus.evict_way_ind_i = box_way;
      bus.evict_flag_i    = box_flag;
      @(negedge clk);
      bus.evict_valid_i   = 1'b0;
      bus.evict_way_ind_i = SA'($urandom);
      bus.evict_flag_i    = 1'($urandom);
      check("evict_req_drop", bus.evict_req_o, 1'b0);
      exp_way = box_way;
      exp_ev  = box_flag;
    end else begin
      check("no_evict_req", bus.evict_req_o, 1'b0);
    end
    check_out(idx, tag, exp_way, is_hit, exp_ev, no_way);
    for (int c = 0; c < stall; c++) begin
      bus.evict_valid_i = 1'($urandom);
      @(negedge clk);
      check_out(idx, tag, exp_way, is_hit, exp_ev, no_way);
    end
    bus.evict_valid_i = 1'b0;
    bus.out_ready_i   = 1'b1;
    clr               = clr_hs;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    clr             = 1'b0;
    if (clr_hs) begin
      m_hit = 0; m_miss = 0; m_evict = 0;
    end else begin
      if (is_hit) m_hit = sat_inc(m_hit);
      if (!is_hit && !no_way) m_miss = sat_inc(m_miss);
      if (exp_ev) m_evict = sat_inc(m_evict);
    end
    check("out_valid_done", bus.out_valid_o, 1'b0);
    check("in_ready_back", bus.in_ready_o, 1'b1);
    check_cnt();
    txn_no++;
    $display("txn %0d idx=%h hit=%h spm=%h -> way=%h hit=%b evict=%b no_way=%b cnt=%0d/%0d/%0d",
             txn_no, idx, hit, spm, exp_way, is_hit, exp_ev, no_way, m_hit, m_miss, m_evict);
  endtask

  initial begin
    logic [SA-1:0] vld, drt, spm, hit;
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.evict_valid_i = 1'b0;
    bus.evict_way_ind_i = '0;
    bus.evict_flag_i = 1'b0;
    bus.out_ready_i = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready_o, 1'b1);
    check("rst_evict_req", bus.evict_req_o, 1'b0);
    check("rst_out_valid", bus.out_valid_o, 1'b0);
    check("rst_out_way", bus.out_way_ind_o, '0);
    check("rst_evict_vec", bus.evict_valid_ways_o, '0);
    check_cnt();

    // Directed: hit, clean miss, dirty miss with backpressure, all-SPM miss.
    run_txn(10'h012, 20'h0abcd, 8'h04, 8'hFF, 8'h00, 8'h00, '0, 0, 0, 1'b0);
    run_txn(10'h033, 20'h11111, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h20, 3, 0, 1'b0);
    run_txn(10'h044, 20'h22222, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01, 1, 5, 1'b0);
    run_txn(10'h055, 20'h33333, 8'h00, 8'h0F, 8'h0F, 8'hFF, '0, 0, 2, 1'b0);

    // Saturation, then a clear that coincides with a counted handshake.
    for (int i = 0; i < 17; i++)
      run_txn(IW'(i), TW'(i), 8'h10, 8'hFF, 8'h00, 8'h00, '0, 0, 0, 1'b0);
    check("hit_saturated", hit_cnt, 4'hF);
    run_txn(10'h3FF, 20'hFFFFF, 8'h80, 8'h80, 8'h80, 8'h00, '0, 0, 1, 1'b1);
    check("hit_cleared", hit_cnt, 4'h0);

    // Reset while the eviction request is outstanding.
    start_txn(10'h066, 20'h44444, 8'h00, 8'hFF, 8'hFF, 8'h00);
    check("evict_req_pre_rst", bus.evict_req_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hit = 0; m_miss = 0; m_evict = 0;
    check("midrst_in_ready", bus.in_ready_o, 1'b1);
    check("midrst_evict_req", bus.evict_req_o, 1'b0);
    check("midrst_out_valid", bus.out_valid_o, 1'b0);
    check_cnt();
    run_txn(10'h077, 20'h55555, 8'h02, 8'h03, 8'h00, 8'h00, '0, 0, 0, 1'b0);

    for (int t = 0; t < 200; t++) begin
      vld = SA'($urandom);
      drt = SA'($urandom);
      spm = ($urandom_range(7, 0) == 0) ? '1 : SA'($urandom & $urandom & $urandom);
      hit = ($urandom_range(1, 0) == 1) ? pick(vld & ~spm) : '0;
      run_txn(IW'($urandom), TW'($urandom), hit, vld, drt, spm, '0,
              $urandom_range(4, 0), $urandom_range(3, 0), ($urandom_range(9, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
